fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8x64 buffer.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_ram.sv | 27 ++
 rtl/fifo_sync_param.sv | 168 ++++++++++++++++
 tb/tb_fifo_sync_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: width math and
// elaboration-time legality check of the parameter set.
package fifo_pkg;

    function automatic int clog2_f(input int value);
        int res;
        res = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 32'sd1;
            end
        end
        return res;
    endfunction

    function automatic bit is_pow2_f(input int value);
        return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

    function automatic bit params_legal_f(input int data_w, input int depth,
                                          input int af_level, input int ae_level);
        return (data_w >= 32'sd1) && (depth >= 32'sd4) && is_pow2_f(depth) &&
               (af_level >= 32'sd1) && (af_level <= depth) &&
               (ae_level >= 32'sd0) && (ae_level <= depth - 32'sd1);
    endfunction

    localparam int DEF_DEPTH = 32'sd64;
    localparam int AW        = clog2_f(DEF_DEPTH);
    localparam int CW        = AW + 32'sd1;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost levels, optional
// first-word-fall-through read, synchronous flush and sticky error flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 64,
    parameter  int AF_LEVEL = 48,
    parameter  int AE_LEVEL = 8,
    parameter  int FWFT     = 0,
    localparam int PAW      = clog2_f(DEPTH),
    localparam int PCW      = PAW + 32'sd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PCW-1:0]    count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    if (!params_legal_f(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    localparam logic [PAW-1:0] PTR_ONE  = {{(PAW-1){1'b0}}, 1'b1};
    localparam logic [PCW-1:0] CNT_ONE  = {{(PCW-1){1'b0}}, 1'b1};
    localparam logic [PCW-1:0] CNT_FULL = PCW'(DEPTH);
    localparam logic [PCW-1:0] CNT_AF   = PCW'(AF_LEVEL);
    localparam logic [PCW-1:0] CNT_AE   = PCW'(AE_LEVEL);

    logic [PAW-1:0]    wr_ptr_r;
    logic [PAW-1:0]    rd_ptr_r;
    logic [PCW-1:0]    count_r;
    logic [PCW-1:0]    count_nxt_s;
    logic              empty_r;
    logic              full_r;
    logic              af_r;
    logic              ae_r;
    logic              ovf_r;
    logic              unf_r;
    logic [DATA_W-1:0] dout_r;
    logic [DATA_W-1:0] ram_rdata_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              ovf_set_s;
    logic              unf_set_s;

    // Accept/reject decisions from the pre-edge flags and the next occupancy
    always_comb begin
        wr_ok_s     = 1'b0;
        rd_ok_s     = 1'b0;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = {PCW{1'b0}};
        end else begin
            wr_ok_s   = wr_en & ~full_r;
            rd_ok_s   = rd_en & ~empty_r;
            ovf_set_s = wr_en & full_r;
            unf_set_s = rd_en & empty_r;
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Occupancy register and flags decoded from the next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {PCW{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
        end else begin
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {PCW{1'b0}});
            full_r  <= (count_nxt_s == CNT_FULL);
            af_r    <= (count_nxt_s >= CNT_AF);
            ae_r    <= (count_nxt_s <= CNT_AE);
        end
    end

    // Read/write pointers; power-of-two depth makes them wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PAW{1'b0}};
            rd_ptr_r <= {PAW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PAW{1'b0}};
            rd_ptr_r <= {PAW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Registered read data for the non-FWFT mode; holds between pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= {DATA_W{1'b0}};
        end else if (flush) begin
            dout_r <= {DATA_W{1'b0}};
        end else if (rd_ok_s) begin
            dout_r <= ram_rdata_s;
        end
    end

    // Sticky error flags; a set condition wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clr_err) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (clr_err) begin
                unf_r <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PAW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok_s),
        .waddr (wr_ptr_r),
        .wdata (din),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    // In FWFT mode the head word is presented straight from the array
    assign dout         = (FWFT != 0) ? ram_rdata_s : dout_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a registered-read instance driven by
// directed vectors plus a small FWFT instance for fall-through behaviour.
module tb_fifo_sync_param;

    localparam int DP = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] din, dout;
    logic       empty, full, almost_full, almost_empty, overflow, underflow;
    logic [6:0] count;

    logic       f_flush, f_wr, f_rd, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [6:0] f_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf, m_unf, rd_pending;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(8), .DEPTH(DP), .AF_LEVEL(48), .AE_LEVEL(8), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err));

    fifo_sync_param #(.DATA_W(8), .DEPTH(DP), .AF_LEVEL(48), .AE_LEVEL(8), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr), .din(f_din),
        .rd_en(f_rd), .dout(f_dout), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), mq.size());
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DP));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= 48));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 8));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock of stimulus on the registered-read FIFO, with model update
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic clr);
        bit m_full, m_empty, ovf_set, unf_set;
        m_full  = (mq.size() == DP);
        m_empty = (mq.size() == 0);
        wr_en = wr; din = d; rd_en = rd; flush = fl; clr_err = clr;
        rd_pending = 1'b0;
        ovf_set = !fl && wr && m_full;
        unf_set = !fl && rd && m_empty;
        if (fl) begin
            mq.delete();
            m_dout = 8'h00;
        end else begin
            if (rd && !m_empty) begin
                m_dout = mq.pop_front();
                exp_q.push_back(m_dout);
                rd_pending = 1'b1;
            end
            if (wr && !m_full) mq.push_back(d);
        end
        if (ovf_set) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (unf_set) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        rd_pending = 1'b0;
        check_state();
    endtask

    // Monitor: registered read data is due just after the edge of an accepted pop
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            if (rd_pending) begin
                #2;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underrun: got read data %0h expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout_read", 32'(dout), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
        f_flush = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = 8'h00;
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00; rd_pending = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_state();
        chk("reset_dout", 32'(dout), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FWFT instance: word written into empty appears one cycle later
        f_wr = 1'b1; f_din = 8'h5A;
        @(negedge clk);
        f_wr = 1'b0;
        chk("fwft_dout_5a", 32'(f_dout), 32'h5A);
        chk("fwft_not_empty", 32'(f_empty), 32'h0);
        @(negedge clk);
        chk("fwft_dout_hold", 32'(f_dout), 32'h5A);
        f_rd = 1'b1;
        @(negedge clk);
        f_rd = 1'b0;
        chk("fwft_empty_after_pop", 32'(f_empty), 32'h1);
        chk("fwft_count_zero", 32'(f_count), 32'h0);
        f_wr = 1'b1; f_din = 8'h11;
        @(negedge clk);
        f_din = 8'h22;
        @(negedge clk);
        f_wr = 1'b0;
        chk("fwft_head_11", 32'(f_dout), 32'h11);
        f_rd = 1'b1;
        @(negedge clk);
        chk("fwft_head_22", 32'(f_dout), 32'h22);
        @(negedge clk);
        f_rd = 1'b0;
        chk("fwft_empty_end", 32'(f_empty), 32'h1);

        // Fill 0x01..0x40, then overflow with 0xAA and clear it
        for (int i = 1; i <= DP; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full_after_64", 32'(full), 32'h1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("overflow_sticky", 32'(overflow), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Drain 64 words in order, then underflow with dout held
        for (int i = 0; i < DP; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("underflow_dout_hold", 32'(dout), 32'h40);
        step(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Read and write together on full: read wins, write dropped
        for (int i = 0; i < DP; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 53; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Steady state at count 10 across pointer wrap
        for (int i = 0; i < 200; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);

        // Flush at count 20 with a write in the same cycle
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        chk("count_20", 32'(count), 32'd20);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("flush_dout_zero", 32'(dout), 32'h0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-burst with underflow pending: everything clears at once
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        wr_en = 1'b1; din = 8'h33;
        rst_n = 1'b0;
        #1;
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;
        check_state();
        chk("reset_mid_dout", 32'(dout), 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        check_state();
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
